// File: rtl/survivor_traceback_pkg.sv
// Shared sizing, FSM encoding and state-index helpers for the survivor traceback unit.
package survivor_traceback_pkg;

  localparam int N_COL   = 8;
  localparam int DEPTH   = 8;
  localparam int STATE_W = 5;
  localparam int COL_W   = 3;
  localparam int REG_W   = 2;
  localparam int STEP_W  = 3;
  localparam int WORD_W  = 32;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_TRACE = 1'b1;

  typedef logic [STATE_W-1:0] state_t;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [REG_W-1:0] rg;
  } state_idx_t;

  // A state selects column s[4:2] and, inside that column word, shift register s[1:0].
  function automatic state_idx_t split_state(input state_t s);
    state_idx_t idx;
    idx.col = s[4:2];
    idx.rg  = s[1:0];
    return idx;
  endfunction

endpackage

// File: rtl/survivor_traceback_if.sv
// Column-word input and decoded-byte output bundle of the survivor traceback unit.
interface survivor_traceback_if;
  import survivor_traceback_pkg::*;

  logic [WORD_W-1:0]  data_in;
  logic [STATE_W-1:0] best_state;
  logic               out_valid;
  logic [DEPTH-1:0]   dec_byte;
  logic [STATE_W-1:0] out_state;

  modport master (
    output data_in, best_state,
    input  out_valid, dec_byte, out_state
  );

  modport slave (
    input  data_in, best_state,
    output out_valid, dec_byte, out_state
  );
endinterface

// File: rtl/survivor_traceback_tb_step.sv
// One traceback step: emit the state's LSB and shift in its stored decision to form the predecessor.
module survivor_traceback_tb_step
  import survivor_traceback_pkg::*;
(
  input  state_t              i_state,
  input  logic [WORD_W-1:0]   i_col_word,
  input  logic [STEP_W-1:0]   i_k,
  output logic                o_bit,
  output state_t              o_pred
);

  state_idx_t                  w_idx;
  logic [REG_W+STEP_W-1:0]     w_bit_sel;

  // Decision bit for register r at depth k lives at 8*r+k of the column word.
  always_comb begin
    w_idx     = split_state(i_state);
    w_bit_sel = {w_idx.rg, i_k};
    o_bit     = i_state[0];
    o_pred    = {i_col_word[w_bit_sel], i_state[STATE_W-1:1]};
  end

endmodule

// File: rtl/survivor_traceback.sv
// Captures one survivor column per clock into ping-pong frame buffers and traces each completed
// frame back 8 stages from the ACS best state, emitting one decoded byte per frame.
module survivor_traceback
  import survivor_traceback_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  survivor_traceback_if.slave  bus
);

  logic [WORD_W-1:0] r_buf [0:1][0:N_COL-1];
  logic [COL_W-1:0]  r_col_cnt;
  logic              r_wr_buf;
  logic              r_rd_buf;
  logic [0:0]        r_fsm;
  logic [STEP_W-1:0] r_step;
  state_t            r_trace_state;
  logic [DEPTH-1:0]  r_dec;
  logic              r_res_vld;
  logic [DEPTH-1:0]  r_res_byte;
  state_t            r_res_state;
  logic              r_out_valid;
  logic [DEPTH-1:0]  r_out_byte;
  state_t            r_out_state;

  state_idx_t        w_idx;
  logic [WORD_W-1:0] w_col_word;
  logic              w_bit;
  state_t            w_pred;
  logic [DEPTH-1:0]  w_byte;
  logic              w_frame_done;
  logic              w_tracing;
  logic              w_last;

  // Select the traced column and merge the current decoded bit into the byte under construction.
  always_comb begin
    w_idx          = split_state(r_trace_state);
    w_col_word     = r_buf[r_rd_buf][w_idx.col];
    w_frame_done   = (r_col_cnt == 3'd7);
    w_tracing      = (r_fsm == ST_TRACE);
    w_last         = w_tracing && (r_step == 3'd7);
    w_byte         = r_dec;
    w_byte[r_step] = w_bit;
  end

  survivor_traceback_tb_step u_step (
    .i_state    (r_trace_state),
    .i_col_word (w_col_word),
    .i_k        (r_step),
    .o_bit      (w_bit),
    .o_pred     (w_pred)
  );

  // Column capture; the counter free-runs to stay locked to the upstream rotation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col_cnt <= 3'd0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < N_COL; c++) begin
          r_buf[b][c] <= 32'd0;
        end
      end
    end else begin
      r_buf[r_wr_buf][r_col_cnt] <= bus.data_in;
      r_col_cnt                  <= r_col_cnt + 3'd1;
    end
  end

  // Frame hand-off and trace FSM; a completed frame takes priority over the final trace step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_buf      <= 1'b0;
      r_rd_buf      <= 1'b0;
      r_fsm         <= ST_IDLE;
      r_step        <= 3'd0;
      r_trace_state <= 5'd0;
      r_dec         <= 8'd0;
    end else begin
      if (w_tracing) begin
        r_dec <= w_byte;
      end
      if (w_frame_done) begin
        r_trace_state <= bus.best_state;
        r_wr_buf      <= ~r_wr_buf;
        r_rd_buf      <= r_wr_buf;
        r_fsm         <= ST_TRACE;
        r_step        <= 3'd0;
      end else if (w_tracing) begin
        r_trace_state <= w_pred;
        r_step        <= r_step + 3'd1;
        r_fsm         <= (r_step == 3'd7) ? ST_IDLE : ST_TRACE;
      end else begin
        r_fsm <= ST_IDLE;
      end
    end
  end

  // The result is parked one cycle so a new frame can reuse the trace state on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_vld   <= 1'b0;
      r_res_byte  <= 8'd0;
      r_res_state <= 5'd0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'd0;
      r_out_state <= 5'd0;
    end else begin
      r_res_vld   <= w_last;
      r_out_valid <= r_res_vld;
      if (w_last) begin
        r_res_byte  <= w_byte;
        r_res_state <= w_pred;
      end
      if (r_res_vld) begin
        r_out_byte  <= r_res_byte;
        r_out_state <= r_res_state;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dec_byte  = r_out_byte;
  assign bus.out_state = r_out_state;

endmodule
